// File: rtl/sqrt_pipe_pkg.sv
// Shared widths and the Stage3 result token for the carry-split sqrt pipeline.
package sqrt_pipe_pkg;

    localparam int unsigned SQ_W    = 20;
    localparam int unsigned ROOT_W  = 8;
    localparam int unsigned CMP_W   = 8;
    localparam int unsigned TAG_W   = 2;

    // One fully resolved Stage3 result, as held in the skid buffer
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [SQ_W-1:0]   square;
        logic [ROOT_W-1:0] root;
        logic              root_ovf;
        logic              lt;
        logic              eq;
    } s3_token_t;

    localparam int unsigned S3_TOKEN_W = $bits(s3_token_t);

endpackage

// File: rtl/s3_skid_buffer.sv
// Two-entry valid/ready skid buffer: a main register driving the outputs and
// one skid register absorbing the token accepted while the main one is held.
// Upstream ready is purely registered, so there is no ready_i -> ready_o path.
module s3_skid_buffer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_main_v;
    logic         r_skid_v;
    logic [W-1:0] r_main_d;
    logic [W-1:0] r_skid_d;
    logic         w_in_xfer;
    logic         w_out_xfer;

    assign o_ready    = ~r_skid_v;
    assign o_valid    = r_main_v;
    assign o_data     = r_main_d;
    assign w_in_xfer  = i_valid & ~r_skid_v;
    assign w_out_xfer = r_main_v & i_ready;

    // Main/skid occupancy and data movement; an in-transfer never coincides
    // with a full skid, so skid refill and skid drain are mutually exclusive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main_d <= '0;
            r_skid_d <= '0;
        end else if (w_out_xfer) begin
            if (r_skid_v) begin
                r_main_d <= r_skid_d;
                r_skid_v <= 1'b0;
            end else if (w_in_xfer) begin
                r_main_d <= i_data;
            end else begin
                r_main_v <= 1'b0;
            end
        end else if (w_in_xfer) begin
            if (!r_main_v) begin
                r_main_d <= i_data;
                r_main_v <= 1'b1;
            end else begin
                r_skid_d <= i_data;
                r_skid_v <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/stage3_finalize.sv
// Stage3 of the carry-split square-root pipeline: resolves the deferred
// carries into a 20-bit candidate square and 8-bit candidate root, computes
// the low-byte compare flags, and registers the result through a skid buffer.
module stage3_finalize #(
    parameter int unsigned SQ_HI_W = 7,
    parameter int unsigned CMP_W   = 8,
    parameter int unsigned ROOT_W  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        S3_valid_i,
    output logic        S3_ready_o,
    input  logic [1:0]  S3_feedback_i,
    input  logic [7:0]  S3_input_l_i,
    input  logic [7:0]  S3_square_l_i,
    input  logic [4:0]  S3_square_sum_i,
    input  logic        S3_Co_square_i,
    input  logic [11:0] S3_A_high_i,
    input  logic [11:0] S3_B_high_i,
    input  logic [3:0]  S3_root_sum_i,
    input  logic        S3_Co_root_i,
    input  logic [3:0]  S3_root_high_i,
    output logic        S3_valid_o,
    input  logic        S3_ready_i,
    output logic [1:0]  S3_feedback_o,
    output logic [19:0] S3_square_o,
    output logic [7:0]  S3_root_o,
    output logic        S3_root_ovf_o,
    output logic        S3_lt_o,
    output logic        S3_eq_o
);

    import sqrt_pipe_pkg::*;

    logic [SQ_HI_W-1:0] w_sq_hi;
    logic [4:0]         w_rh_sum;
    logic [ROOT_W-1:0]  w_root;
    logic               w_unused_addend_lo;
    s3_token_t          w_in_tok;
    s3_token_t          w_out_tok;

    // Only bits [11:5] of the upper addends feed the square; the low bits
    // were already folded into square_sum by Stage2.
    assign w_unused_addend_lo = ^{S3_A_high_i[4:0], S3_B_high_i[4:0]};

    assign w_sq_hi  = S3_A_high_i[11 -: SQ_HI_W] + S3_B_high_i[11 -: SQ_HI_W]
                    + SQ_HI_W'(S3_Co_square_i);
    assign w_rh_sum = {1'b0, S3_root_high_i} + {4'b0000, S3_Co_root_i};
    assign w_root   = {w_rh_sum[3:0], S3_root_sum_i};

    assign w_in_tok.tag      = S3_feedback_i;
    assign w_in_tok.square   = {w_sq_hi, S3_square_sum_i, S3_square_l_i};
    assign w_in_tok.root     = w_root;
    assign w_in_tok.root_ovf = w_rh_sum[4];
    assign w_in_tok.lt       = S3_input_l_i[CMP_W-1:0] <  S3_square_l_i[CMP_W-1:0];
    assign w_in_tok.eq       = S3_input_l_i[CMP_W-1:0] == S3_square_l_i[CMP_W-1:0];

    s3_skid_buffer #(
        .W (S3_TOKEN_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (S3_valid_i),
        .o_ready (S3_ready_o),
        .i_data  (w_in_tok),
        .o_valid (S3_valid_o),
        .i_ready (S3_ready_i),
        .o_data  (w_out_tok)
    );

    assign S3_feedback_o = w_out_tok.tag;
    assign S3_square_o   = w_out_tok.square;
    assign S3_root_o     = w_out_tok.root;
    assign S3_root_ovf_o = w_out_tok.root_ovf;
    assign S3_lt_o       = w_out_tok.lt;
    assign S3_eq_o       = w_out_tok.eq;

endmodule

// File: tb/tb_stage3_finalize.sv
// Self-checking bench for stage3_finalize: table vectors, random stream,
// stall/skid sequence and mid-stall reset, checked through a scoreboard.
module tb_stage3_finalize;

    typedef struct {
        logic [1:0]  tag;
        logic [7:0]  inl;
        logic [7:0]  sql;
        logic [4:0]  ssum;
        logic        cosq;
        logic [11:0] a;
        logic [11:0] b;
        logic [3:0]  rsum;
        logic        cor;
        logic [3:0]  rhigh;
    } stim_t;

    typedef struct packed {
        logic [1:0]  tag;
        logic [19:0] sq;
        logic [7:0]  root;
        logic        ovf;
        logic        lt;
        logic        eq;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        S3_valid_i, S3_ready_o, S3_Co_square_i, S3_Co_root_i;
    logic [1:0]  S3_feedback_i;
    logic [7:0]  S3_input_l_i, S3_square_l_i;
    logic [4:0]  S3_square_sum_i;
    logic [11:0] S3_A_high_i, S3_B_high_i;
    logic [3:0]  S3_root_sum_i, S3_root_high_i;
    logic        S3_valid_o, S3_ready_i, S3_root_ovf_o, S3_lt_o, S3_eq_o;
    logic [1:0]  S3_feedback_o;
    logic [19:0] S3_square_o;
    logic [7:0]  S3_root_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    exp_t sbq[$];
    exp_t cur_exp;

    stage3_finalize dut (
        .clk             (clk),
        .rst             (rst),
        .S3_valid_i      (S3_valid_i),
        .S3_ready_o      (S3_ready_o),
        .S3_feedback_i   (S3_feedback_i),
        .S3_input_l_i    (S3_input_l_i),
        .S3_square_l_i   (S3_square_l_i),
        .S3_square_sum_i (S3_square_sum_i),
        .S3_Co_square_i  (S3_Co_square_i),
        .S3_A_high_i     (S3_A_high_i),
        .S3_B_high_i     (S3_B_high_i),
        .S3_root_sum_i   (S3_root_sum_i),
        .S3_Co_root_i    (S3_Co_root_i),
        .S3_root_high_i  (S3_root_high_i),
        .S3_valid_o      (S3_valid_o),
        .S3_ready_i      (S3_ready_i),
        .S3_feedback_o   (S3_feedback_o),
        .S3_square_o     (S3_square_o),
        .S3_root_o       (S3_root_o),
        .S3_root_ovf_o   (S3_root_ovf_o),
        .S3_lt_o         (S3_lt_o),
        .S3_eq_o         (S3_eq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Arithmetic reference: weights instead of concatenation
    function automatic exp_t model(input stim_t s);
        exp_t        e;
        int unsigned hi;
        int unsigned r;
        hi = ((int'(s.a) >> 5) + (int'(s.b) >> 5) + int'(s.cosq)) % 128;
        r  = int'(s.rhigh) + int'(s.cor);
        e.tag  = s.tag;
        e.sq   = 20'(hi * 8192 + int'(s.ssum) * 256 + int'(s.sql));
        e.root = 8'((r % 16) * 16 + int'(s.rsum));
        e.ovf  = (r > 15);
        e.lt   = (s.inl < s.sql);
        e.eq   = (s.inl == s.sql);
        return e;
    endfunction

    function automatic stim_t rand_stim(input logic [1:0] tag);
        stim_t s;
        s.tag   = tag;
        s.inl   = 8'($urandom);
        s.sql   = 8'($urandom);
        s.ssum  = 5'($urandom);
        s.cosq  = 1'($urandom);
        s.a     = 12'($urandom);
        s.b     = 12'($urandom);
        s.rsum  = 4'($urandom);
        s.cor   = 1'($urandom);
        s.rhigh = 4'($urandom);
        return s;
    endfunction

    task automatic set_inputs(input stim_t s, input exp_t e);
        S3_feedback_i   = s.tag;
        S3_input_l_i    = s.inl;
        S3_square_l_i   = s.sql;
        S3_square_sum_i = s.ssum;
        S3_Co_square_i  = s.cosq;
        S3_A_high_i     = s.a;
        S3_B_high_i     = s.b;
        S3_root_sum_i   = s.rsum;
        S3_Co_root_i    = s.cor;
        S3_root_high_i  = s.rhigh;
        cur_exp         = e;
        S3_valid_i      = 1'b1;
    endtask

    // Offer a token and return #1 after the edge on which it was accepted
    task automatic send(input stim_t s, input exp_t e, output int waited);
        bit accepted;
        accepted = 0;
        waited   = 0;
        set_inputs(s, e);
        for (int k = 0; k < 64 && !accepted; k++) begin
            @(negedge clk);
            if (S3_ready_o) accepted = 1;
            waited++;
            @(posedge clk);
            #1;
        end
        if (!accepted) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        S3_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: push on in-transfer, pop and compare on out-transfer
    always @(negedge clk) begin
        if (!rst) begin
            if (S3_valid_i && S3_ready_o) sbq.push_back(cur_exp);
            if (S3_valid_o && S3_ready_i) begin
                exp_t e;
                n_out++;
                if (sbq.size() == 0) begin
                    check("spurious_output", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check("token", 64'({S3_feedback_o, S3_square_o, S3_root_o,
                                        S3_root_ovf_o, S3_lt_o, S3_eq_o}), 64'(e));
                end
            end
        end
    end

    initial begin
        vec_t  tbl[4];
        stim_t s;
        stim_t st[3];
        int    w;
        int    base;

        tbl[0].s = '{tag:2'd0, inl:8'h9B, sql:8'h9C, ssum:5'h13, cosq:1'b1,
                     a:12'hA40, b:12'h060, rsum:4'h7, cor:1'b1, rhigh:4'hF};
        tbl[0].e = '{tag:2'd0, sq:20'hAD39C, root:8'h07, ovf:1'b1, lt:1'b1, eq:1'b0};
        tbl[1].s = '{tag:2'd1, inl:8'h9C, sql:8'h9C, ssum:5'h00, cosq:1'b0,
                     a:12'h000, b:12'h000, rsum:4'h5, cor:1'b0, rhigh:4'h3};
        tbl[1].e = '{tag:2'd1, sq:20'h0009C, root:8'h35, ovf:1'b0, lt:1'b0, eq:1'b1};
        tbl[2].s = '{tag:2'd2, inl:8'hFF, sql:8'h00, ssum:5'h1F, cosq:1'b1,
                     a:12'hFFF, b:12'hFFF, rsum:4'hA, cor:1'b0, rhigh:4'hF};
        tbl[2].e = '{tag:2'd2, sq:20'hFFF00, root:8'hFA, ovf:1'b0, lt:1'b0, eq:1'b0};
        tbl[3].s = '{tag:2'd3, inl:8'h00, sql:8'h55, ssum:5'h0A, cosq:1'b0,
                     a:12'h0E0, b:12'h01F, rsum:4'h0, cor:1'b1, rhigh:4'h8};
        tbl[3].e = '{tag:2'd3, sq:20'h0EA55, root:8'h90, ovf:1'b0, lt:1'b1, eq:1'b0};

        rst = 1'b1;
        S3_ready_i = 1'b1;
        S3_valid_i = 1'b0;
        set_inputs(tbl[0].s, tbl[0].e);
        S3_valid_i = 1'b0;
        #2;
        check("reset_valid_o", 64'(S3_valid_o), 64'd0);
        check("reset_ready_o", 64'(S3_ready_o), 64'd1);
        check("reset_data", 64'({S3_feedback_o, S3_square_o, S3_root_o,
                                 S3_root_ovf_o, S3_lt_o, S3_eq_o}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Table vectors, unstalled: 1-cycle latency each
        for (int i = 0; i < 4; i++) begin
            send(tbl[i].s, tbl[i].e, w);
            check("table_latency_valid", 64'(S3_valid_o), 64'd1);
        end
        idle(3);

        // Back-to-back random stream, ready_i held high
        for (int k = 0; k < 16; k++) begin
            s = rand_stim(2'(k));
            send(s, model(s), w);
            check("stream_no_stall", 64'(w), 64'd1);
            check("stream_valid_cont", 64'(S3_valid_o), 64'd1);
        end
        idle(3);
        check("stream_drained", 64'(sbq.size()), 64'd0);

        // Stall: tags 0,1,2 offered while downstream blocks
        for (int i = 0; i < 3; i++) st[i] = rand_stim(2'(i));
        S3_ready_i = 1'b0;
        send(st[0], model(st[0]), w);
        check("stall_valid_tag0", 64'(S3_valid_o), 64'd1);
        check("stall_ready_after_tag0", 64'(S3_ready_o), 64'd1);
        send(st[1], model(st[1]), w);
        check("stall_ready_skid_full", 64'(S3_ready_o), 64'd0);
        check("stall_hold_tag0", 64'(S3_feedback_o), 64'd0);
        set_inputs(st[2], model(st[2]));
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("stall_still_blocked", 64'(S3_ready_o), 64'd0);
        check("stall_held_square", 64'(S3_square_o), 64'(model(st[0]).sq));
        base = n_out;
        S3_ready_i = 1'b1;
        send(st[2], model(st[2]), w);
        check("stall_tag2_wait", 64'(w), 64'd2);
        idle(3);
        check("stall_out_count", 64'(n_out - base), 64'd3);
        check("stall_drained", 64'(sbq.size()), 64'd0);

        // Reset mid-stall with both entries full
        S3_ready_i = 1'b0;
        s = rand_stim(2'd1);
        send(s, model(s), w);
        s = rand_stim(2'd2);
        send(s, model(s), w);
        S3_valid_i = 1'b0;
        check("prereset_full", 64'({S3_valid_o, S3_ready_o}), 64'b10);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid_o", 64'(S3_valid_o), 64'd0);
        check("midrst_ready_o", 64'(S3_ready_o), 64'd1);
        check("midrst_data", 64'({S3_feedback_o, S3_square_o, S3_root_o,
                                  S3_root_ovf_o, S3_lt_o, S3_eq_o}), 64'd0);
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        S3_ready_i = 1'b1;
        #1;
        check("postrst_empty", 64'(S3_valid_o), 64'd0);
        s = rand_stim(2'd3);
        send(s, model(s), w);
        check("postrst_latency", 64'(S3_valid_o), 64'd1);
        idle(3);
        check("final_drained", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
